// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: IDLE->EXEC(L cycles)->DONE, with one response held until rsp_ready.
// Fixed priority to requester 0 by default; define ALU_ARBITER_RR_EN for round-robin arbitration.
module alu_arbiter #(
  parameter int N         = 8,
  parameter int SHIFT_LAT = 1,
  parameter int MUL_LAT   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_y,
  output logic [N-1:0] rsp_y_ext,
  output logic         rsp_flg,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_inp,
  input  logic [N-1:0] alu_y,
  input  logic [N-1:0] alu_y_ext,
  input  logic         alu_flg,
  output logic         busy
);

  localparam int MAX_LAT = (MUL_LAT > SHIFT_LAT) ? MUL_LAT : SHIFT_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          grant_vld;
  logic          grant_id;
  logic [2:0]    sel_op;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;

`ifdef ALU_ARBITER_RR_EN
  logic prio_q;
`endif

  // Counter is loaded with L-1 so that EXEC lasts exactly L cycles.
  function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
    case (op)
      3'b101, 3'b110: lat_m1 = CW'(SHIFT_LAT - 1);
      3'b111:         lat_m1 = CW'(MUL_LAT - 1);
      default:        lat_m1 = '0;
    endcase
  endfunction

  always_comb begin
    grant_vld = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    grant_id  = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_RR_EN
      grant_id = prio_q;
`else
      grant_id = 1'b0;
`endif
    end
    sel_op = grant_id ? req1_op : req0_op;
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_y_ext <= '0;
      rsp_flg   <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_inp   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            alu_op  <= sel_op;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            rsp_id  <= grant_id;
            cnt_q   <= lat_m1(sel_op);
            alu_inp <= 1'b1;
            busy    <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_y     <= alu_y;
            rsp_y_ext <= alu_y_ext;
            // Only add/sub produce a meaningful flag.
            rsp_flg   <= (alu_op[2:1] == 2'b00) && alu_flg;
            rsp_valid <= 1'b1;
            alu_inp   <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (grant_vld) begin
      prio_q <= ~grant_id;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus randomized transactions against a transaction-level model.
module tb_alu_arbiter;
  localparam int N  = 8;
  localparam int SL = 3;
  localparam int ML = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_id, rsp_flg, busy, alu_inp, alu_flg;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_y, rsp_y_ext, alu_a, alu_b, alu_y, alu_y_ext;
  logic [2:0]   alu_op;

  int checks = 0;
  int failures = 0;
  int last_k = 1;
  logic [N-1:0] obs_y, obs_yext;
  logic         obs_flg, obs_id;
  int           obs_lat;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .SHIFT_LAT(SL), .MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_y_ext(rsp_y_ext),
    .rsp_flg(rsp_flg), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp),
    .alu_y(alu_y), .alu_y_ext(alu_y_ext), .alu_flg(alu_flg), .busy(busy)
  );

  // Stand-in ALU: returns {flag, upper, lower}; non-arith ops raise the flag so masking is visible.
  function automatic logic [2*N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0]   y, ye;
    logic           f;
    logic [2*N-1:0] p;
    y = '0; ye = '0; f = 1'b1; p = '0;
    case (op)
      3'd0: {f, y} = {1'b0, a} + {1'b0, b};
      3'd1: begin y = a - b; f = (a < b); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << b[2:0];
      3'd6: y = a >> b[2:0];
      default: begin p = a * b; {ye, y} = p; end
    endcase
    return {f, ye, y};
  endfunction

  assign {alu_flg, alu_y_ext, alu_y} = alu_fn(alu_op, alu_a, alu_b);

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'd7) return ML;
    if (op == 3'd5 || op == 3'd6) return SL;
    return 1;
  endfunction

  function automatic int exp_winner(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARBITER_RR_EN
      return (last_k == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit v0, input bit v1,
                     input logic [2:0] op0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                     input logic [2:0] op1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                     input int hold);
    int w, lat, inp_cnt, L;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic [2*N:0] e;
    logic         ef;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    w = exp_winner(v0, v1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("grant", 32'({req1_ready, req0_ready}), 32'((w == 1) ? 2'b10 : 2'b01));
    op = (w == 1) ? op1 : op0;
    a  = (w == 1) ? a1 : a0;
    b  = (w == 1) ? b1 : b0;
    L  = exp_lat(op);
    e  = alu_fn(op, a, b);
    ef = (op < 3'd2) ? e[2*N] : 1'b0;
    step();
    last_k = w;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rdy", 32'({req1_ready, req0_ready}), 32'd0);
    chk("latched", 32'({rsp_id, alu_op, alu_a, alu_b}), 32'({w[0], op, a, b}));
    lat = 1; inp_cnt = 0;
    while (!rsp_valid && lat <= 40) begin
      if (alu_inp) inp_cnt++;
      step();
      lat++;
    end
    obs_lat = lat; obs_y = rsp_y; obs_yext = rsp_y_ext; obs_flg = rsp_flg; obs_id = rsp_id;
    chk("rsp_latency", 32'(lat), 32'(L + 1));
    chk("inp_cycles", 32'(inp_cnt), 32'(L));
    chk("done_inp", 32'(alu_inp), 32'd0);
    chk("rsp_data", 32'({rsp_id, rsp_flg, rsp_y_ext, rsp_y}), 32'({w[0], ef, e[2*N-1:0]}));
    chk("alu_hold", 32'({alu_op, alu_a, alu_b}), 32'({op, a, b}));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_stable", 32'({rsp_valid, rsp_id, rsp_flg, rsp_y_ext, rsp_y}), 32'({1'b1, w[0], ef, e[2*N-1:0]}));
      chk("bp_rdy_busy", 32'({req1_ready, req0_ready, busy}), 32'b001);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs", 32'({rsp_valid, busy}), 32'd0);
    chk("reaccept", 32'(req0_ready | req1_ready), 32'(v0 | v1));
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order;
    int         seen;
    bit         rv0, rv1;

    // Reset state, with a request pending to show ready is gated off.
    rst_n = 1'b0;
    step(); step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_rdy", 32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_ctrl", 32'({rsp_valid, busy, alu_inp, rsp_id, rsp_flg}), 32'd0);
    chk("rst_data", 32'({alu_op, alu_a, alu_b}), 32'd0);
    chk("rst_rsp", 32'({rsp_y_ext, rsp_y}), 32'd0);
    rst_n = 1'b1;
    step();

    // Single add
    txn(1, 0, 3'd0, 8'h7F, 8'h01, 3'd0, 8'h00, 8'h00, 0);
    chk("add_lit", 32'({obs_id, obs_yext, obs_y}), 32'h00080);
    chk("add_lat", 32'(obs_lat), 32'd2);

    // Multiply
    txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd7, 8'h10, 8'h10, 0);
    chk("mul_lit", 32'({obs_yext, obs_y}), 32'h0100);
    chk("mul_id_flg", 32'({obs_id, obs_flg}), 32'b10);
    chk("mul_lat", 32'(obs_lat), 32'd9);

    // Shift latency and flag masking
    txn(1, 0, 3'd5, 8'h81, 8'h03, 3'd0, 8'h00, 8'h00, 0);
    chk("shl_lit", 32'({obs_flg, obs_y}), 32'h008);

    // Backpressure with both requesters waiting
    txn(1, 1, 3'd2, 8'hF0, 8'h3C, 3'd4, 8'hAA, 8'h55, 5);

    // Contention from a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1; last_k = 1; step();
    order = '0;
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 3'd0, 8'(i), 8'h01, 3'd1, 8'(i), 8'h01, 0);
      order[i] = obs_id;
    end
`ifdef ALU_ARBITER_RR_EN
    chk("rr_order", 32'(order), 32'b1010);
`else
    chk("fixed_order", 32'(order), 32'b0000);
`endif

    // Reset in the third EXEC cycle of a multiply
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 8'h12; req0_b = 8'h34;
    step();
    req0_valid = 1'b0;
    step(); step();
    chk("mid_mul_inp", 32'({alu_inp, busy}), 32'b11);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    last_k = 1;
    chk("abort_ctrl", 32'({busy, alu_inp, rsp_valid}), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid || busy) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    txn(1, 0, 3'd1, 8'd3, 8'd5, 3'd0, 8'h00, 8'h00, 0);
    chk("sub_lit", 32'({obs_flg, obs_y}), 32'h1FE);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      txn(rv0, rv1, 3'($urandom), 8'($urandom), 8'($urandom),
          3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
